// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Purpose : bundles the serial-side inputs and the byte-side outputs of
//           uart_rx so the receiver and its environment share one handle.
// Signals :
//   baud_tick   - 16x oversample enable from baud_gen (one sys_clk wide)
//   rx          - raw serial line, idle high, asynchronous to sys_clk
//   rx_data     - last correctly framed byte, held between frames
//   rx_valid    - one-cycle strobe, rx_data has just been updated
//   framing_err - one-cycle strobe, stop bit sampled low
//   parity_err  - one-cycle strobe, parity mismatch (0 when parity is off)
//   busy        - receiver state machine is not idle
// Modports:
//   master - the environment: drives baud_tick/rx, observes the results
//   slave  - the receiver itself
// ----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 framing_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output baud_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  framing_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  baud_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output framing_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Purpose : UART receiver fed by baud_gen's oversample enable. Recovers
//           LSB-first frames (start, DATA_BITS data, optional parity, one
//           stop bit) from the asynchronous rx line and presents each byte
//           as a one-cycle strobe. Everything runs in the sys_clk domain;
//           baud_tick is an enable, never a clock.
// Ports   :
//   sys_clk  - system clock, rising edge
//   reset_n  - asynchronous assert, active-low reset
//   bus      - uart_rx_if.slave: baud_tick, rx in; rx_data, rx_valid,
//              framing_err, parity_err, busy out
// Parameters:
//   DATA_BITS  - data bits per frame (5..9)
//   OVERSAMPLE - baud_tick pulses per bit period, even and >= 4
//   PARITY_ODD - parity sense when parity is enabled: 0 even, 1 odd
// Build option:
//   UART_RX_PARITY_EN - when defined a parity bit follows the data bits and
//                       parity_err is live; when undefined the parity state
//                       is removed and parity_err is tied low.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic     sys_clk,
    input  logic     reset_n,
    uart_rx_if.slave bus
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    // Tick count at which the start bit is judged (half a bit in) and at
    // which every later bit is sampled (a full bit after the previous one).
    localparam logic [TCW-1:0] TICK_HALF = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rx_s;

    logic [TCW-1:0]        r_tick_cnt;
    logic [TCW-1:0]        w_tick_nxt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [BCW-1:0]        w_bit_nxt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_nxt;

    logic [DATA_BITS-1:0]  r_rx_data;
    logic [DATA_BITS-1:0]  w_data_nxt;
    logic                  r_rx_valid;
    logic                  w_valid_nxt;
    logic                  r_framing_err;
    logic                  w_ferr_nxt;
    logic                  w_mid_bit;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);

    logic                  r_parity_err;
    logic                  w_perr_nxt;
    logic                  r_par_bad;
    logic                  w_par_bad_nxt;
`else
    logic                  w_unused_par;
    assign w_unused_par = (PARITY_ODD != 0);
`endif

    // The receiver only ever looks at the twice-registered copy of rx.
    assign w_rx_s    = r_sync2;
    assign w_mid_bit = (r_tick_cnt == TICK_LAST);

    // State register, synchronizer and all datapath registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= 1'b0;
            r_par_bad     <= 1'b0;
`endif
        end else begin
            r_sync1       <= bus.rx;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_tick_cnt    <= w_tick_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_rx_data     <= w_data_nxt;
            r_rx_valid    <= w_valid_nxt;
            r_framing_err <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_parity_err  <= w_perr_nxt;
            r_par_bad     <= w_par_bad_nxt;
`endif
        end
    end

    // Next-state and datapath logic. Nothing moves except on baud_tick; the
    // strobes default low every cycle so each one lasts a single sys_clk.
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick_cnt;
        w_bit_nxt     = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_rx_data;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt    = 1'b0;
        w_par_bad_nxt = r_par_bad;
`endif

        if (bus.baud_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end

                // A start bit that is no longer low half a bit in was noise.
                S_START: begin
                    if (r_tick_cnt == TICK_HALF) begin
                        w_tick_nxt = '0;
                        if (!w_rx_s) begin
                            w_state_nxt   = S_DATA;
                            w_bit_nxt     = '0;
`ifdef UART_RX_PARITY_EN
                            w_par_bad_nxt = 1'b0;
`endif
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TCW'(1);
                    end
                end

                // Line order is LSB first, so shifting in at the MSB leaves
                // bit 0 at position 0 once all bits have arrived.
                S_DATA: begin
                    if (w_mid_bit) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit_cnt + BCW'(1);
                        if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TCW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                // The mismatch is only remembered here; it is reported (or
                // overridden by a framing error) once the stop bit is seen.
                S_PARITY: begin
                    if (w_mid_bit) begin
                        w_par_bad_nxt = w_rx_s ^ (^r_shift) ^ PAR_SENSE;
                        w_tick_nxt    = '0;
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + TCW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (w_mid_bit) begin
                        w_tick_nxt = '0;
                        if (w_rx_s) begin
                            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                w_perr_nxt = 1'b1;
                            end else begin
                                w_data_nxt  = r_shift;
                                w_valid_nxt = 1'b1;
                            end
`else
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
`endif
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TCW'(1);
                    end
                end

                // Park here while the line is held low so a break yields a
                // single framing error rather than a stream of bogus frames.
                S_BREAK: begin
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.framing_err = r_framing_err;
    assign bus.busy        = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = r_parity_err;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Purpose : self-checking bench for uart_rx. baud_tick fires every 4 sys_clk
//           cycles, so one bit period is 64 cycles. A strobe monitor records
//           every receiver event; each frame's outcome is compared with the
//           outcome predicted from the frame's bits.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int PARITY_ODD = 0;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CYCLES = TICK_DIV * OVERSAMPLE;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int K_VALID  = 0;
    localparam int K_FRAME  = 1;
    localparam int K_PARITY = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } event_t;

    typedef struct {
        logic [7:0] data;
        logic       parBit;
        logic       stopBit;
        int         gapBits;
        int         expKind;
        logic [7:0] expRxData;
    } vec_t;

    logic   sysClk;
    logic   resetN;
    event_t obsQ[$];
    int     checks;
    int     errors;
    bit     prevStrobe;
    logic [7:0] modelData;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .sys_clk(sysClk),
        .reset_n(resetN),
        .bus    (bus)
    );

    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    // Oversample enable: one cycle high out of every TICK_DIV.
    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge sysClk);
            bus.baud_tick = 1'b1;
            @(negedge sysClk);
            bus.baud_tick = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Strobe monitor: every strobe must be alone in its cycle and one cycle
    // wide; each one is queued for the frame-level comparison.
    always @(negedge sysClk) begin
        int nStrobes;
        if (resetN) begin
            nStrobes = int'(bus.rx_valid) + int'(bus.framing_err) + int'(bus.parity_err);
            if (nStrobes > 0) begin
                checkOutput("strobe_exclusive", nStrobes, 1);
                checkOutput("strobe_width", 32'(prevStrobe), 0);
                if (bus.rx_valid)
                    obsQ.push_back('{K_VALID, bus.rx_data});
                else if (bus.framing_err)
                    obsQ.push_back('{K_FRAME, 8'h00});
                else
                    obsQ.push_back('{K_PARITY, 8'h00});
            end
            prevStrobe = (nStrobes > 0);
        end else begin
            prevStrobe = 1'b0;
        end
    end

    // Reference model: the outcome of a frame follows directly from its bits.
    function automatic int modelKind(input logic [7:0] data, input logic parBit,
                                     input logic stopBit);
        if (!stopBit)
            return K_FRAME;
        if (PAR_EN && (parBit != ((^data) ^ (PARITY_ODD != 0))))
            return K_PARITY;
        return K_VALID;
    endfunction

    task automatic driveBit(input logic b);
        bus.rx = b;
        repeat (BIT_CYCLES) @(negedge sysClk);
    endtask

    // One serial frame, LSB first, then gapBits idle-high bit periods. With
    // no gap the line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic parBit,
                                 input logic stopBit, input int gapBits);
        driveBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++)
            driveBit(data[i]);
        if (PAR_EN)
            driveBit(parBit);
        driveBit(stopBit);
        if (gapBits > 0) begin
            bus.rx = 1'b1;
            repeat (gapBits * BIT_CYCLES) @(negedge sysClk);
        end
    endtask

    task automatic checkFrame(input string tag, input int expKind,
                              input logic [7:0] expData, input logic [7:0] expHeld,
                              input logic expBusy);
        event_t ev;
        checkOutput({tag, "_count"}, obsQ.size(), 1);
        if (obsQ.size() > 0) begin
            ev = obsQ.pop_front();
            checkOutput({tag, "_kind"}, ev.kind, expKind);
            if (expKind == K_VALID)
                checkOutput({tag, "_data"}, ev.data, expData);
        end
        obsQ.delete();
        checkOutput({tag, "_rx_data"}, bus.rx_data, expHeld);
        checkOutput({tag, "_busy"}, bus.busy, expBusy);
    endtask

    initial begin
        vec_t       tbl[8];
        logic [7:0] partial;
        logic [7:0] rData;
        logic       rPar;
        logic       rStop;
        int         rGap;
        int         rKind;

        checks     = 0;
        errors     = 0;
        prevStrobe = 1'b0;
        modelData  = 8'h00;
        bus.rx     = 1'b1;
        resetN     = 1'b0;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1, K_VALID, 8'hA5};
        tbl[1] = '{8'h00, 1'b0, 1'b1, 0, K_VALID, 8'h00};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 0, K_VALID, 8'hFF};
        tbl[3] = '{8'h3C, 1'b0, 1'b1, 1, K_VALID, 8'h3C};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 2, K_FRAME, 8'h3C};
        tbl[5] = '{8'h03, 1'b0, 1'b1, 1, K_VALID, 8'h03};
        tbl[6] = '{8'h03, 1'b1, 1'b1, 1, (PAR_EN ? K_PARITY : K_VALID), 8'h03};
        tbl[7] = '{8'h5A, 1'b0, 1'b1, 1, K_VALID, 8'h5A};

        // Reset state
        repeat (3) @(negedge sysClk);
        checkOutput("reset_rx_data", bus.rx_data, 8'h00);
        checkOutput("reset_rx_valid", bus.rx_valid, 0);
        checkOutput("reset_framing_err", bus.framing_err, 0);
        checkOutput("reset_parity_err", bus.parity_err, 0);
        checkOutput("reset_busy", bus.busy, 0);
        resetN = 1'b1;
        repeat (BIT_CYCLES) @(negedge sysClk);
        checkOutput("post_reset_busy", bus.busy, 0);

        // Directed table: single frame, back-to-back, framing, parity cases
        $display("[TB] directed table");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(tbl[v].data, tbl[v].parBit, tbl[v].stopBit, tbl[v].gapBits);
            checkFrame($sformatf("tbl%0d", v), tbl[v].expKind, tbl[v].data,
                       tbl[v].expRxData, 1'b0);
        end
        modelData = 8'h5A;

        // Glitch: two ticks of low line must not start a frame
        $display("[TB] glitch rejection");
        bus.rx = 1'b0;
        repeat (8) @(negedge sysClk);
        checkOutput("glitch_busy_during", bus.busy, 1);
        bus.rx = 1'b1;
        repeat (BIT_CYCLES) @(negedge sysClk);
        checkOutput("glitch_events", obsQ.size(), 0);
        checkOutput("glitch_busy_after", bus.busy, 0);
        checkOutput("glitch_rx_data", bus.rx_data, modelData);

        // Framing error followed by a 20-bit break
        $display("[TB] framing and break");
        applyStimulus(8'h55, 1'b0, 1'b0, 0);
        checkFrame("break_frame", K_FRAME, 8'h00, modelData, 1'b1);
        for (int b = 0; b < 20; b++) begin
            repeat (BIT_CYCLES) @(negedge sysClk);
            if (b % 5 == 4)
                checkOutput($sformatf("break_busy_%0d", b), bus.busy, 1);
        end
        checkOutput("break_extra_events", obsQ.size(), 0);
        bus.rx = 1'b1;
        repeat (4 * TICK_DIV) @(negedge sysClk);
        checkOutput("break_busy_release", bus.busy, 0);
        checkOutput("break_rx_data", bus.rx_data, modelData);

        // Reset in the middle of data bit 3 of 0xC3
        $display("[TB] reset mid-frame");
        partial = 8'hC3;
        driveBit(1'b0);
        for (int i = 0; i < 3; i++)
            driveBit(partial[i]);
        bus.rx = partial[3];
        repeat (BIT_CYCLES / 2) @(negedge sysClk);
        checkOutput("pre_reset_busy", bus.busy, 1);
        resetN = 1'b0;
        #1;
        checkOutput("async_reset_rx_data", bus.rx_data, 8'h00);
        checkOutput("async_reset_busy", bus.busy, 0);
        checkOutput("async_reset_rx_valid", bus.rx_valid, 0);
        checkOutput("async_reset_framing_err", bus.framing_err, 0);
        checkOutput("async_reset_parity_err", bus.parity_err, 0);
        modelData = 8'h00;
        @(negedge sysClk);
        bus.rx = 1'b1;
        repeat (4) @(negedge sysClk);
        resetN = 1'b1;
        repeat (2 * BIT_CYCLES) @(negedge sysClk);
        checkOutput("reset_abort_events", obsQ.size(), 0);
        applyStimulus(8'h81, 1'b0, 1'b1, 1);
        modelData = 8'h81;
        checkFrame("after_reset", K_VALID, 8'h81, modelData, 1'b0);

        // Randomized frames against the reference model
        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            rData = 8'($urandom);
            rStop = ($urandom_range(0, 6) != 0);
            rPar  = (^rData) ^ (PARITY_ODD != 0);
            if ($urandom_range(0, 5) == 0)
                rPar = ~rPar;
            rGap  = rStop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            rKind = modelKind(rData, rPar, rStop);
            if (rKind == K_VALID)
                modelData = rData;
            applyStimulus(rData, rPar, rStop, rGap);
            checkFrame($sformatf("rnd%0d", n), rKind, rData, modelData, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
